// File: rtl/if_refill_if.sv
// AXI4 read address/data channels between the I-cache refill engine (master) and memory (slave).
interface if_refill_if;
  logic [63:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid;
  logic        m_arready;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic        m_rvalid;
  logic        m_rready;

  modport master (
    output m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    input  m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
  );

  modport slave (
    input  m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    output m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
  );
endinterface

// File: rtl/if_refill.sv
// I-cache refill: one AXI4 INCR burst of B 64-bit beats per miss, written into the data array, then a done pulse.
// IF_REFILL_ERR_EN adds a sticky refill_err for non-OKAY RRESP or a misplaced RLAST.
module if_refill #(
  parameter int B = 8,
  parameter int b = 3,
  parameter int y = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          IF_miss,
  input  logic [63:0]   IF_addr,
  output logic          refill_busy,
  output logic          refill_done,
  output logic [63:0]   refill_line,
  output logic          wr_en,
  output logic [b-1:0]  wr_idx,
  output logic [63:0]   wr_data,
`ifdef IF_REFILL_ERR_EN
  output logic          refill_err,
`endif
  if_refill_if.master   axi
);

  localparam int             OFF       = b + y;
  localparam logic [63:0]    LINE_MASK = (64'd1 << OFF) - 64'd1;
  localparam logic [b-1:0]   LAST      = b'(B - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t        state_q, state_d;
  logic [63:0]   line_q, line_d;
  logic [b-1:0]  cnt_q, cnt_d;
  logic          wr_en_q, wr_en_d;
  logic [b-1:0]  wr_idx_q, wr_idx_d;
  logic [63:0]   wr_data_q, wr_data_d;
  logic          last_wr;

`ifdef IF_REFILL_ERR_EN
  logic          err_q, err_d;
`else
  logic          unused_rsp;
  assign unused_rsp = ^{axi.m_rresp, axi.m_rlast};
`endif

  // The final beat's write is still on the array port; hold off R and leave DATA next cycle.
  assign last_wr = wr_en_q && (wr_idx_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      line_q    <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
`ifdef IF_REFILL_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
`ifdef IF_REFILL_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    line_d        = line_q;
    cnt_d         = cnt_q;
    wr_en_d       = 1'b0;
    wr_idx_d      = wr_idx_q;
    wr_data_d     = wr_data_q;
`ifdef IF_REFILL_ERR_EN
    err_d         = err_q;
`endif
    axi.m_arvalid = 1'b0;
    axi.m_rready  = 1'b0;
    refill_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (IF_miss) begin
          line_d  = IF_addr & ~LINE_MASK;
          cnt_d   = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        axi.m_arvalid = 1'b1;
        if (axi.m_arready) state_d = DATA;
      end
      DATA: begin
        if (last_wr) begin
          state_d = DONE;
        end else begin
          axi.m_rready = 1'b1;
          if (axi.m_rvalid) begin
            wr_en_d   = 1'b1;
            wr_idx_d  = cnt_q;
            wr_data_d = axi.m_rdata;
            cnt_d     = cnt_q + 1'b1;
`ifdef IF_REFILL_ERR_EN
            if ((axi.m_rresp != 2'b00) || (axi.m_rlast != (cnt_q == LAST))) err_d = 1'b1;
`endif
          end
        end
      end
      DONE: begin
        refill_done = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign refill_busy   = (state_q != IDLE);
  assign refill_line   = line_q;
  assign wr_en         = wr_en_q;
  assign wr_idx        = wr_idx_q;
  assign wr_data       = wr_data_q;
  assign axi.m_araddr  = line_q;
  assign axi.m_arlen   = 8'(B - 1);
  assign axi.m_arsize  = 3'b011;
  assign axi.m_arburst = 2'b01;
`ifdef IF_REFILL_ERR_EN
  assign refill_err    = err_q;
`endif

endmodule

// File: tb/tb_if_refill.sv
// Scoreboard bench for if_refill: expected array writes are queued as beats are sent and checked as wr_en appears.
`timescale 1ns/1ps
module tb_if_refill;
  localparam int B = 8;

  logic        clk;
  logic        reset_n;
  logic        IF_miss;
  logic [63:0] IF_addr;
  logic        refill_busy;
  logic        refill_done;
  logic [63:0] refill_line;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [63:0] wr_data;
`ifdef IF_REFILL_ERR_EN
  logic        refill_err;
`endif

  if_refill_if axi();

  if_refill #(.B(B), .b(3), .y(3)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .IF_miss     (IF_miss),
    .IF_addr     (IF_addr),
    .refill_busy (refill_busy),
    .refill_done (refill_done),
    .refill_line (refill_line),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
`ifdef IF_REFILL_ERR_EN
    .refill_err  (refill_err),
`endif
    .axi         (axi)
  );

  typedef struct {
    logic [2:0]  idx;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every array write must match the oldest beat sent.
  always @(posedge clk) begin
    #1;
    if (wr_en === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_write unexpected write idx=%0d data=%h, none expected", wr_idx, wr_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (wr_idx !== e.idx || wr_data !== e.data)
          $display("FAIL sb_write got idx=%0d data=%h want idx=%0d data=%h", wr_idx, wr_data, e.idx, e.data);
        else
          n_pass++;
      end
    end
  end

  // Miss stimulus plus AXI slave; times are cycles since IF_miss was raised.
  task automatic refill(input logic [63:0] addr, input int ar_wait, input bit gaps,
                        input int drop_beat, input int rst_beat, input int err_beat,
                        output int t_ar, output int t_done, output int n_wr, output int n_bad,
                        output int n_arv, output logic [63:0] ar0, output int t_err);
    int t = 0;
    int beats = 0;
    int arw = 0;
    bit hs_prev = 1'b0;
    bit phase = 1'b0;
    t_ar = -1; t_done = -1; n_wr = 0; n_bad = 0; n_arv = 0; ar0 = '0; t_err = -1;
    IF_miss = 1'b1;
    IF_addr = addr;
    while (t < 300) begin
      @(negedge clk);
      t++;
      if (wr_en) begin
        n_wr++;
        if (!hs_prev) n_bad++;
      end
      if (wr_en && refill_done) n_bad++;
`ifdef IF_REFILL_ERR_EN
      if (refill_err && t_err < 0) t_err = t;
`endif
      if (axi.m_arvalid) begin
        n_arv++;
        if (t_ar < 0) begin
          t_ar = t;
          ar0  = axi.m_araddr;
        end else if (axi.m_araddr !== ar0) begin
          n_bad++;
        end
      end
      if (refill_done) begin
        t_done = t;
        IF_miss = 1'b0;
        axi.m_rvalid = 1'b0;
        axi.m_arready = 1'b0;
        return;
      end
      if (rst_beat >= 0 && beats == rst_beat) begin
        IF_miss = 1'b0;
        axi.m_rvalid = 1'b0;
        axi.m_arready = 1'b0;
        return;
      end
      if (drop_beat >= 0 && beats >= drop_beat) IF_miss = 1'b0;
      axi.m_arready = 1'b0;
      if (axi.m_arvalid) begin
        if (arw < ar_wait) arw++;
        else axi.m_arready = 1'b1;
      end
      axi.m_rvalid = 1'b0;
      if (axi.m_rready && beats < B) begin
        if (!gaps || phase) begin
          axi.m_rvalid = 1'b1;
          axi.m_rdata  = 64'h1000 + 64'(beats);
          axi.m_rresp  = (beats == err_beat) ? 2'b10 : 2'b00;
          axi.m_rlast  = (beats == B - 1);
          exp_q.push_back('{idx: 3'(beats), data: 64'h1000 + 64'(beats)});
          beats++;
        end
        phase = !phase;
      end
      hs_prev = axi.m_rvalid && axi.m_rready;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (refill_busy !== 1'b0) $display("FAIL rst_busy got %b want 0", refill_busy); else n_pass++;
    n_chk++; if (refill_done !== 1'b0) $display("FAIL rst_done got %b want 0", refill_done); else n_pass++;
    n_chk++; if (wr_en !== 1'b0) $display("FAIL rst_wr_en got %b want 0", wr_en); else n_pass++;
    n_chk++; if (refill_line !== 64'h0) $display("FAIL rst_line got %h want 0", refill_line); else n_pass++;
    n_chk++; if (axi.m_arvalid !== 1'b0) $display("FAIL rst_arvalid got %b want 0", axi.m_arvalid); else n_pass++;
    n_chk++; if (axi.m_rready !== 1'b0) $display("FAIL rst_rready got %b want 0", axi.m_rready); else n_pass++;
    n_chk++; if (axi.m_arlen !== 8'd7) $display("FAIL rst_arlen got %0d want 7", axi.m_arlen); else n_pass++;
    n_chk++; if (axi.m_arsize !== 3'b011) $display("FAIL rst_arsize got %b want 011", axi.m_arsize); else n_pass++;
    n_chk++; if (axi.m_arburst !== 2'b01) $display("FAIL rst_arburst got %b want 01", axi.m_arburst); else n_pass++;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int ta, td, nw, nb, na, te;
    logic [63:0] a0;
    refill(64'h8000_0124, 0, 1'b0, -1, -1, -1, ta, td, nw, nb, na, a0, te);
    n_chk++; if (ta !== 1) $display("FAIL basic_ar_cycle got %0d want 1", ta); else n_pass++;
    n_chk++; if (a0 !== 64'h8000_0100) $display("FAIL basic_araddr got %h want 80000100", a0); else n_pass++;
    n_chk++; if (nw !== 8) $display("FAIL basic_writes got %0d want 8", nw); else n_pass++;
    n_chk++; if (td !== 11) $display("FAIL basic_done_cycle got %0d want 11", td); else n_pass++;
    n_chk++; if (nb !== 0) $display("FAIL basic_protocol got %0d violations want 0", nb); else n_pass++;
    n_chk++; if (refill_busy !== 1'b1) $display("FAIL basic_busy_at_done got %b want 1", refill_busy); else n_pass++;
    @(negedge clk);
    n_chk++; if (refill_busy !== 1'b0) $display("FAIL basic_busy_after got %b want 0", refill_busy); else n_pass++;
    n_chk++; if (refill_line !== 64'h8000_0100) $display("FAIL basic_line got %h want 80000100", refill_line); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_ar_backpressure();
    int ta, td, nw, nb, na, te;
    logic [63:0] a0;
    refill(64'h8000_0124, 5, 1'b0, -1, -1, -1, ta, td, nw, nb, na, a0, te);
    n_chk++; if (na !== 6) $display("FAIL arbp_arvalid_cycles got %0d want 6", na); else n_pass++;
    n_chk++; if (nb !== 0) $display("FAIL arbp_stability got %0d violations want 0", nb); else n_pass++;
    n_chk++; if (td !== 16) $display("FAIL arbp_done_cycle got %0d want 16", td); else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_r_gaps();
    int ta, td, nw, nb, na, te;
    logic [63:0] a0;
    refill(64'h0000_1238, 0, 1'b1, -1, -1, -1, ta, td, nw, nb, na, a0, te);
    n_chk++; if (nw !== 8) $display("FAIL gaps_writes got %0d want 8", nw); else n_pass++;
    n_chk++; if (nb !== 0) $display("FAIL gaps_write_timing got %0d violations want 0", nb); else n_pass++;
    n_chk++; if (td !== 19) $display("FAIL gaps_done_cycle got %0d want 19", td); else n_pass++;
    n_chk++; if (a0 !== 64'h0000_1200) $display("FAIL gaps_araddr got %h want 00001200", a0); else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int ta, td, nw, nb, na, te;
    logic [63:0] a0;
    refill(64'h8000_0124, 0, 1'b0, 3, -1, -1, ta, td, nw, nb, na, a0, te);
    n_chk++; if (td !== 11) $display("FAIL b2b_drop_done got %0d want 11", td); else n_pass++;
    n_chk++; if (nw !== 8) $display("FAIL b2b_drop_writes got %0d want 8", nw); else n_pass++;
    refill(64'h8000_0200, 0, 1'b0, -1, -1, -1, ta, td, nw, nb, na, a0, te);
    n_chk++; if (ta !== 2) $display("FAIL b2b_ar_after_done got %0d want 2", ta); else n_pass++;
    n_chk++; if (a0 !== 64'h8000_0200) $display("FAIL b2b_araddr got %h want 80000200", a0); else n_pass++;
    n_chk++; if (td !== 12) $display("FAIL b2b_done_cycle got %0d want 12", td); else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    int ta, td, nw, nb, na, te;
    int n_done = 0;
    logic [63:0] a0;
    refill(64'h8000_0124, 0, 1'b0, -1, 4, -1, ta, td, nw, nb, na, a0, te);
    n_chk++; if (nw !== 4) $display("FAIL mrst_writes_before got %0d want 4", nw); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_chk++; if (wr_en !== 1'b0) $display("FAIL mrst_wr_en got %b want 0", wr_en); else n_pass++;
    n_chk++; if (refill_busy !== 1'b0) $display("FAIL mrst_busy got %b want 0", refill_busy); else n_pass++;
    n_chk++; if (refill_line !== 64'h0) $display("FAIL mrst_line got %h want 0", refill_line); else n_pass++;
    n_chk++; if (axi.m_araddr !== 64'h0) $display("FAIL mrst_araddr got %h want 0", axi.m_araddr); else n_pass++;
    n_chk++; if (wr_data !== 64'h0 || wr_idx !== 3'd0) $display("FAIL mrst_wr_port got idx=%0d data=%h want 0", wr_idx, wr_data); else n_pass++;
    n_chk++; if (axi.m_rready !== 1'b0) $display("FAIL mrst_rready got %b want 0", axi.m_rready); else n_pass++;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      if (refill_done) n_done++;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (refill_done) n_done++;
    end
    n_chk++; if (n_done !== 0) $display("FAIL mrst_no_done got %0d pulses want 0", n_done); else n_pass++;
    refill(64'h8000_0124, 0, 1'b0, -1, -1, -1, ta, td, nw, nb, na, a0, te);
    n_chk++; if (ta !== 1) $display("FAIL mrst_ar_cycle got %0d want 1", ta); else n_pass++;
    n_chk++; if (a0 !== 64'h8000_0100) $display("FAIL mrst_araddr_again got %h want 80000100", a0); else n_pass++;
    n_chk++; if (nw !== 8) $display("FAIL mrst_writes got %0d want 8", nw); else n_pass++;
    n_chk++; if (td !== 11) $display("FAIL mrst_done_cycle got %0d want 11", td); else n_pass++;
    repeat (2) @(negedge clk);
  endtask

`ifdef IF_REFILL_ERR_EN
  task automatic test_err();
    int ta, td, nw, nb, na, te;
    logic [63:0] a0;
    n_chk++; if (refill_err !== 1'b0) $display("FAIL err_initial got %b want 0", refill_err); else n_pass++;
    refill(64'h8000_0124, 0, 1'b0, -1, -1, 2, ta, td, nw, nb, na, a0, te);
    n_chk++; if (te !== 5) $display("FAIL err_rise_cycle got %0d want 5", te); else n_pass++;
    n_chk++; if (nw !== 8) $display("FAIL err_writes got %0d want 8", nw); else n_pass++;
    n_chk++; if (td !== 11) $display("FAIL err_done_cycle got %0d want 11", td); else n_pass++;
    repeat (4) @(negedge clk);
    n_chk++; if (refill_err !== 1'b1) $display("FAIL err_sticky got %b want 1", refill_err); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_chk++; if (refill_err !== 1'b0) $display("FAIL err_reset got %b want 0", refill_err); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    reset_n       = 1'b0;
    IF_miss       = 1'b0;
    IF_addr       = '0;
    axi.m_arready = 1'b0;
    axi.m_rvalid  = 1'b0;
    axi.m_rdata   = '0;
    axi.m_rresp   = 2'b00;
    axi.m_rlast   = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_ar_backpressure();
    test_r_gaps();
    test_back_to_back();
    test_reset_mid_burst();
`ifdef IF_REFILL_ERR_EN
    test_err();
`endif
    n_chk++;
    if (exp_q.size() !== 0) $display("FAIL sb_drain got %0d pending writes want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
